// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_pkg
//  Purpose  : Shared state encoding and constants for divided-clock monitors.
//  Revision : 1.0  initial release
// ============================================================================
package clk_pkg;

    // Monitor state encoding, 3 bits wide.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        LOST    = 3'd4
    } mon_state_e;

    // Width of the saturating error-event counter.
    localparam int ERR_CNT_W = 8;

endpackage : clk_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_det
//  Purpose  : Two-flop synchroniser plus history flop for a slow asynchronous
//             signal. Gives rise/fall pulses and the synchronised level.
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge_det (
    input  logic clk_i,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic meta;
    logic sync;
    logic hist;

    // Shift the raw input through the metastability pair and into the history flop.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    // Pulses are decoded from flop outputs only, so they are glitch-free.
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;
    assign level = sync;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_monitor
//  Purpose  : Checks a divided clock in the clk_i domain: edge strobes,
//             half/full period measurement, lock, error and loss detection.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_monitor
    import clk_pkg::*;
#(
    parameter int EXP_HALF = 5,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 mon_clk_i,
    input  logic                 en_i,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic [CNT_W-1:0]     period_o,
    output logic                 period_vld_o,
    output logic                 lock_o,
    output logic                 err_o,
    output logic                 loss_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int LO_INT = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam logic [CNT_W:0]     LO_BOUND  = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0]     HI_BOUND  = (CNT_W+1)'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0]  LOCK_C    = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0]  GOOD_ONE  = GOOD_W'(1);

    logic                 s_rise;
    logic                 s_fall;
    logic                 s_level;
    logic                 edge_any;
    logic                 is_rise;
    logic [CNT_W-1:0]     seg_cnt;
    logic [CNT_W:0]       len_ext;
    logic                 half_good;
    logic                 timed_out;
    logic [CNT_W:0]       period_sum;
    logic [CNT_W-1:0]     period_sat;
    mon_state_e           state;
    logic [GOOD_W-1:0]    good_cnt;
    logic [CNT_W-1:0]     high_len;
    logic                 high_seen;

    sync_edge_det u_sync (
        .clk_i (clk_i),
        .rst   (rst),
        .din   (mon_clk_i),
        .rise  (s_rise),
        .fall  (s_fall),
        .level (s_level)
    );

    assign edge_any  = s_rise | s_fall;
    assign is_rise   = s_level;

    // The half just ended is the pre-update segment count; compare one bit wider.
    assign len_ext   = {1'b0, seg_cnt};
    assign half_good = (len_ext >= LO_BOUND) && (len_ext <= HI_BOUND);
    assign timed_out = (seg_cnt >= TIMEOUT_C);

    // At a rise the low half is the current segment, so the period needs only the latched high half.
    assign period_sum = {1'b0, high_len} + len_ext;
    assign period_sat = period_sum[CNT_W] ? {CNT_W{1'b1}} : period_sum[CNT_W-1:0];

    // Segment counter: restarts at 1 on every edge, saturates at all-ones.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            seg_cnt <= '0;
        end else if (!en_i) begin
            seg_cnt <= '0;
        end else if (edge_any) begin
            seg_cnt <= CNT_W'(1);
        end else if (seg_cnt != {CNT_W{1'b1}}) begin
            seg_cnt <= seg_cnt + CNT_W'(1);
        end
    end

    // Monitor FSM with registered strobes, status, period latch and error counter.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            good_cnt     <= '0;
            high_len     <= '0;
            high_seen    <= 1'b0;
            rise_o       <= 1'b0;
            fall_o       <= 1'b0;
            period_o     <= '0;
            period_vld_o <= 1'b0;
            lock_o       <= 1'b0;
            err_o        <= 1'b0;
            loss_o       <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            rise_o       <= edge_any & is_rise;
            fall_o       <= edge_any & ~is_rise;
            period_vld_o <= 1'b0;
            err_o        <= 1'b0;
            if (!en_i) begin
                state     <= IDLE;
                good_cnt  <= '0;
                high_len  <= '0;
                high_seen <= 1'b0;
                period_o  <= '0;
                lock_o    <= 1'b0;
                loss_o    <= 1'b0;
                err_cnt_o <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end
                    ACQUIRE, LOST: begin
                        // First edge only gives a phase reference; its partial half is never judged.
                        if (edge_any) begin
                            state     <= MEASURE;
                            good_cnt  <= '0;
                            high_seen <= 1'b0;
                            loss_o    <= 1'b0;
                        end else if (state == ACQUIRE && timed_out) begin
                            state    <= LOST;
                            loss_o   <= 1'b1;
                            good_cnt <= '0;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (edge_any) begin
                            if (is_rise) begin
                                if (high_seen) begin
                                    period_o     <= period_sat;
                                    period_vld_o <= 1'b1;
                                end
                            end else begin
                                high_len  <= seg_cnt;
                                high_seen <= 1'b1;
                            end
                            if (half_good) begin
                                if (state == MEASURE) begin
                                    if (good_cnt + GOOD_ONE == LOCK_C) begin
                                        state    <= LOCKED;
                                        lock_o   <= 1'b1;
                                        good_cnt <= '0;
                                    end else begin
                                        good_cnt <= good_cnt + GOOD_ONE;
                                    end
                                end
                            end else begin
                                good_cnt <= '0;
                                if (state == LOCKED) begin
                                    state  <= MEASURE;
                                    lock_o <= 1'b0;
                                    err_o  <= 1'b1;
                                    if (err_cnt_o != {ERR_CNT_W{1'b1}}) begin
                                        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                                    end
                                end
                            end
                        end else if (timed_out) begin
                            state    <= LOST;
                            loss_o   <= 1'b1;
                            lock_o   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : clk_div_monitor
`default_nettype wire
